// File: rtl/bpm_mux_integrator_if.sv
// Bus bundle for bpm_mux_integrator.
// master: drives the strobe/close controls, channel selects and packed I/Q
//         samples, and observes the live sums, latched results and flags.
// slave : the integrator itself.
// Signals: bunch_strb, dac_cond, sel[N_OUT*SEL_W], in_i/in_q[N_IN*IN_W] (in);
//          acc_i/acc_q/res_i/res_q[N_OUT*ACC_W], res_valid, res_count[CNT_W],
//          sat_flag[2*N_OUT], overrun (out).
interface bpm_mux_integrator_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int SEL_W = 2,
  parameter int IN_W  = 13,
  parameter int ACC_W = 15,
  parameter int CNT_W = 4
);
  logic                   bunch_strb;
  logic                   dac_cond;
  logic [N_OUT*SEL_W-1:0] sel;
  logic [N_IN*IN_W-1:0]   in_i;
  logic [N_IN*IN_W-1:0]   in_q;
  logic [N_OUT*ACC_W-1:0] acc_i;
  logic [N_OUT*ACC_W-1:0] acc_q;
  logic [N_OUT*ACC_W-1:0] res_i;
  logic [N_OUT*ACC_W-1:0] res_q;
  logic                   res_valid;
  logic [CNT_W-1:0]       res_count;
  logic [2*N_OUT-1:0]     sat_flag;
  logic                   overrun;

  modport master (
    output bunch_strb, dac_cond, sel, in_i, in_q,
    input  acc_i, acc_q, res_i, res_q, res_valid, res_count, sat_flag, overrun
  );

  modport slave (
    input  bunch_strb, dac_cond, sel, in_i, in_q,
    output acc_i, acc_q, res_i, res_q, res_valid, res_count, sat_flag, overrun
  );
endinterface

// File: rtl/bpm_mux_integrator.sv
// N-input to M-output BPM channel multiplexer and bunch-strobe integrator.
// Each output k accumulates the I/Q pair of the input channel named by select
// field k; the select is captured on the first strobe of a window and held
// until the window closes. dac_cond closes the window: sums, sample count and
// saturation flags are latched into the res_* registers with a one-cycle
// res_valid pulse, and the live accumulators clear.
// Ports: clk, rst (sync, active-high), bus (bpm_mux_integrator_if.slave).
module bpm_mux_integrator #(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 2,
  parameter int SEL_W       = 2,
  parameter int IN_W        = 13,
  parameter int ACC_W       = 15,
  parameter int SAT_EN      = 1,
  parameter int MAX_SAMPLES = 8,
  parameter int CNT_W       = 4
) (
  input logic                  clk,
  input logic                  rst,
  bpm_mux_integrator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, INTEG, FULL} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Returns {clip_flag, sum}. The sum is formed one bit wider than the
  // accumulator so overflow shows up as a mismatch of the top two bits.
  function automatic logic [ACC_W:0] add_clip(input logic signed [ACC_W-1:0] a,
                                               input logic signed [IN_W-1:0]  b);
    logic [ACC_W:0] s;
    logic           ovf;
    s   = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};
    ovf = s[ACC_W] ^ s[ACC_W-1];
    if (SAT_EN != 0 && ovf) begin
      add_clip = {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    end else begin
      add_clip = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [N_OUT*SEL_W-1:0]  sel_q;
  logic signed [ACC_W-1:0] acc_i_p1 [N_OUT];
  logic signed [ACC_W-1:0] acc_q_p1 [N_OUT];
  logic [2*N_OUT-1:0]      sat_win;
  logic signed [ACC_W-1:0] res_i_p2 [N_OUT];
  logic signed [ACC_W-1:0] res_q_p2 [N_OUT];
  logic [CNT_W-1:0]        res_count_p2;
  logic [2*N_OUT-1:0]      sat_flag_p2;
  logic                    vld_p2;
  logic                    overrun_r;

  logic [N_OUT*SEL_W-1:0]  sel_eff;
  logic signed [IN_W-1:0]  samp_i [N_OUT];
  logic signed [IN_W-1:0]  samp_q [N_OUT];
  logic signed [ACC_W-1:0] acc_i_nxt [N_OUT];
  logic signed [ACC_W-1:0] acc_q_nxt [N_OUT];
  logic [2*N_OUT-1:0]      sat_hit;
  logic [CNT_W-1:0]        cnt_inc;

  // ---- stage 0: channel select and add/clip ----
  always_comb begin
    // The first strobe of a window routes with the live select; afterwards
    // the captured copy is used so mid-window select changes are ignored.
    sel_eff = (state == IDLE) ? bus.sel : sel_q;
    sat_hit = '0;
    cnt_inc = cnt + 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      samp_i[k] = '0;
      samp_q[k] = '0;
      // Out-of-range select fields match no channel and contribute zero.
      for (int j = 0; j < N_IN; j++) begin
        if (sel_eff[k*SEL_W +: SEL_W] == SEL_W'(j)) begin
          samp_i[k] = bus.in_i[j*IN_W +: IN_W];
          samp_q[k] = bus.in_q[j*IN_W +: IN_W];
        end
      end
      {sat_hit[2*k],   acc_i_nxt[k]} = add_clip(acc_i_p1[k], samp_i[k]);
      {sat_hit[2*k+1], acc_q_nxt[k]} = add_clip(acc_q_p1[k], samp_q[k]);
    end
  end

  // ---- stage 1: window FSM and accumulators; stage 2: result latch ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sel_q        <= '0;
      sat_win      <= '0;
      res_count_p2 <= '0;
      sat_flag_p2  <= '0;
      vld_p2       <= 1'b0;
      overrun_r    <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        acc_i_p1[k] <= '0;
        acc_q_p1[k] <= '0;
        res_i_p2[k] <= '0;
        res_q_p2[k] <= '0;
      end
    end else begin
      vld_p2 <= 1'b0;
      if (bus.bunch_strb) begin
        // A strobe wins over a simultaneous dac_cond.
        case (state)
          IDLE: begin
            sel_q   <= bus.sel;
            cnt     <= cnt_inc;
            sat_win <= sat_win | sat_hit;
            for (int k = 0; k < N_OUT; k++) begin
              acc_i_p1[k] <= acc_i_nxt[k];
              acc_q_p1[k] <= acc_q_nxt[k];
            end
            state <= (MAX_SAMPLES == 1) ? FULL : INTEG;
          end
          INTEG: begin
            cnt     <= cnt_inc;
            sat_win <= sat_win | sat_hit;
            for (int k = 0; k < N_OUT; k++) begin
              acc_i_p1[k] <= acc_i_nxt[k];
              acc_q_p1[k] <= acc_q_nxt[k];
            end
            if (cnt_inc == CNT_W'(MAX_SAMPLES)) state <= FULL;
          end
          FULL: begin
            overrun_r <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (bus.dac_cond) begin
        res_count_p2 <= cnt;
        sat_flag_p2  <= sat_win;
        vld_p2       <= 1'b1;
        cnt          <= '0;
        sat_win      <= '0;
        state        <= IDLE;
        for (int k = 0; k < N_OUT; k++) begin
          res_i_p2[k] <= acc_i_p1[k];
          res_q_p2[k] <= acc_q_p1[k];
          acc_i_p1[k] <= '0;
          acc_q_p1[k] <= '0;
        end
      end
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign bus.acc_i[k*ACC_W +: ACC_W] = acc_i_p1[k];
    assign bus.acc_q[k*ACC_W +: ACC_W] = acc_q_p1[k];
    assign bus.res_i[k*ACC_W +: ACC_W] = res_i_p2[k];
    assign bus.res_q[k*ACC_W +: ACC_W] = res_q_p2[k];
  end

  assign bus.res_valid = vld_p2;
  assign bus.res_count = res_count_p2;
  assign bus.sat_flag  = sat_flag_p2;
  assign bus.overrun   = overrun_r;

endmodule
